// File: rtl/wb_stage_pkg.sv
// Shared types for the XPU write-back stage: load size encodings and FSM states.
package xpu_wb_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage to write-back handshake plus the data-memory load response.
// Signal suffixes are from the write-back stage's point of view.
interface wb_stage_if #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
);
    logic               mem_valid_i;
    logic               mem_ready_o;
    logic               mem_wen_i;
    logic [RADDR_W-1:0] mem_rd_i;
    logic [XLEN-1:0]    mem_result_i;
    logic               mem_is_load_i;
    logic [1:0]         mem_ld_size_i;
    logic               mem_ld_unsigned_i;
    logic [XLEN-1:0]    mem_pc_i;
    logic               dmem_rvalid_i;
    logic [XLEN-1:0]    dmem_rdata_i;

    modport master (
        output mem_valid_i, mem_wen_i, mem_rd_i, mem_result_i, mem_is_load_i,
               mem_ld_size_i, mem_ld_unsigned_i, mem_pc_i,
               dmem_rvalid_i, dmem_rdata_i,
        input  mem_ready_o
    );

    modport slave (
        input  mem_valid_i, mem_wen_i, mem_rd_i, mem_result_i, mem_is_load_i,
               mem_ld_size_i, mem_ld_unsigned_i, mem_pc_i,
               dmem_rvalid_i, dmem_rdata_i,
        output mem_ready_o
    );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational lane select and sign/zero extension of a returned load doubleword.
module load_extend
    import xpu_wb_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  ld_size_e    size,
    input  logic        is_unsigned,
    output logic [63:0] ext_data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] word_lane;

    // Offset bits below the access size are dropped; alignment is upstream's job.
    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = rdata[{offset[2:1], 4'b0000} +: 16];
    assign word_lane = rdata[{offset[2], 5'b00000} +: 32];

    always_comb begin
        ext_data = rdata;
        case (size)
            LD_B:    ext_data = {{56{byte_lane[7]  & ~is_unsigned}}, byte_lane};
            LD_H:    ext_data = {{48{half_lane[15] & ~is_unsigned}}, half_lane};
            LD_W:    ext_data = {{32{word_lane[31] & ~is_unsigned}}, word_lane};
            default: ext_data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// XPU_v0.1 write-back stage: retires MEM-stage instructions into the register file,
// holding loads until the data-memory response arrives.
module wb_stage
    import xpu_wb_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    wb_stage_if.slave          bus,
    output logic               rf_we_o,
    output logic [RADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]    rf_wdata_o,
    output logic               commit_valid_o,
    output logic [XLEN-1:0]    commit_pc_o,
    output logic               load_pending_o
);
    wb_state_e          state_q, state_d;

    logic               ld_wen_q, ld_wen_d;
    logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]         ld_off_q, ld_off_d;
    ld_size_e           ld_size_q, ld_size_d;
    logic               ld_uns_q, ld_uns_d;
    logic [XLEN-1:0]    ld_pc_q, ld_pc_d;

    logic               rf_we_q, rf_we_d;
    logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
    logic               commit_valid_q, commit_valid_d;
    logic [XLEN-1:0]    commit_pc_q, commit_pc_d;

    logic [63:0]        ext_data;

    load_extend u_load_extend (
        .rdata       (bus.dmem_rdata_i),
        .offset      (ld_off_q),
        .size        (ld_size_q),
        .is_unsigned (ld_uns_q),
        .ext_data    (ext_data)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d        = state_q;
        ld_wen_d       = ld_wen_q;
        ld_rd_d        = ld_rd_q;
        ld_off_d       = ld_off_q;
        ld_size_d      = ld_size_q;
        ld_uns_d       = ld_uns_q;
        ld_pc_d        = ld_pc_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;

        case (state_q)
            WB_IDLE: begin
                if (bus.mem_valid_i) begin
                    if (bus.mem_is_load_i) begin
                        ld_wen_d  = bus.mem_wen_i;
                        ld_rd_d   = bus.mem_rd_i;
                        ld_off_d  = bus.mem_result_i[2:0];
                        ld_size_d = ld_size_e'(bus.mem_ld_size_i);
                        ld_uns_d  = bus.mem_ld_unsigned_i;
                        ld_pc_d   = bus.mem_pc_i;
                        state_d   = WB_WAIT_LOAD;
                    end else begin
                        rf_we_d        = bus.mem_wen_i && (bus.mem_rd_i != '0);
                        rf_waddr_d     = bus.mem_rd_i;
                        rf_wdata_d     = bus.mem_result_i;
                        commit_valid_d = 1'b1;
                        commit_pc_d    = bus.mem_pc_i;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (bus.dmem_rvalid_i) begin
                    rf_we_d        = ld_wen_q && (ld_rd_q != '0);
                    rf_waddr_d     = ld_rd_q;
                    rf_wdata_d     = ext_data;
                    commit_valid_d = 1'b1;
                    commit_pc_d    = ld_pc_q;
                    state_d        = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // NOTE: synchronous active-low reset; state updates use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= WB_IDLE;
            ld_wen_q       <= 1'b0;
            ld_rd_q        <= '0;
            ld_off_q       <= '0;
            ld_size_q      <= LD_B;
            ld_uns_q       <= 1'b0;
            ld_pc_q        <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            state_q        <= state_d;
            ld_wen_q       <= ld_wen_d;
            ld_rd_q        <= ld_rd_d;
            ld_off_q       <= ld_off_d;
            ld_size_q      <= ld_size_d;
            ld_uns_q       <= ld_uns_d;
            ld_pc_q        <= ld_pc_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

    assign bus.mem_ready_o = (state_q == WB_IDLE);
    assign load_pending_o  = (state_q == WB_WAIT_LOAD);
    assign rf_we_o         = rf_we_q;
    assign rf_waddr_o      = rf_waddr_q;
    assign rf_wdata_o      = rf_wdata_q;
    assign commit_valid_o  = commit_valid_q;
    assign commit_pc_o     = commit_pc_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-scenario tasks plus a commit scoreboard.
module tb_wb_stage;
    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic        load_pending_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    wb_stage_if #(.XLEN(64), .RADDR_W(5)) bus ();

    wb_stage #(.XLEN(64), .RADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .load_pending_o (load_pending_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every commit pulse is matched in order against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checks++;
            if (commit_valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit: pc=%h we=%b, none expected", commit_pc_o, rf_we_o);
                end else begin
                    e = sb.pop_front();
                    if (rf_we_o !== e.we || commit_pc_o !== e.pc ||
                        (e.we && (rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata))) begin
                        errors++;
                        $display("FAIL commit_data: got we=%b rd=%0d data=%h pc=%h, want we=%b rd=%0d data=%h pc=%h",
                                 rf_we_o, rf_waddr_o, rf_wdata_o, commit_pc_o, e.we, e.waddr, e.wdata, e.pc);
                    end
                end
            end else if (rf_we_o !== 1'b0) begin
                errors++;
                $display("FAIL write_without_commit: rf_we_o=%b, want 0", rf_we_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic is_load, input logic wen, input logic [4:0] rd,
                          input logic [63:0] result, input logic [1:0] size,
                          input logic uns, input logic [63:0] pc);
        bus.mem_valid_i       = 1'b1;
        bus.mem_is_load_i     = is_load;
        bus.mem_wen_i         = wen;
        bus.mem_rd_i          = rd;
        bus.mem_result_i      = result;
        bus.mem_ld_size_i     = size;
        bus.mem_ld_unsigned_i = uns;
        bus.mem_pc_i          = pc;
    endtask

    // Returns one step after the accepting edge with mem_valid_i still driven.
    task automatic wait_accept(input string name);
        logic accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.mem_ready_o;
            tick();
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: mem_ready_o=%b, want 1 within 20 cycles", name, bus.mem_ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_rf: we=%b waddr=%0d wdata=%h, want 0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        checks++;
        if (commit_valid_o !== 1'b0 || commit_pc_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_commit: valid=%b pc=%h, want 0/0", commit_valid_o, commit_pc_o);
        end
        checks++;
        if (bus.mem_ready_o !== 1'b1 || load_pending_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b pending=%b, want 1/0", bus.mem_ready_o, load_pending_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        sb.push_back('{1'b1, 5'd5, 64'h1234, 64'h1000});
        sb.push_back('{1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004});
        set_op(1'b0, 1'b1, 5'd5, 64'h1234, 2'd0, 1'b0, 64'h1000);
        wait_accept("b2b_first");
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5) begin
            errors++;
            $display("FAIL b2b_first_write: we=%b waddr=%0d, want 1/5", rf_we_o, rf_waddr_o);
        end
        set_op(1'b0, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 64'h1004);
        wait_accept("b2b_second");
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd6) begin
            errors++;
            $display("FAIL b2b_second_write: we=%b waddr=%0d, want 1/6", rf_we_o, rf_waddr_o);
        end
        bus.mem_valid_i = 1'b0;
        tick();
        checks++;
        if (rf_we_o !== 1'b0 || commit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after: we=%b commit=%b, want 0/0", rf_we_o, commit_valid_o);
        end
    endtask

    task automatic test_load(input string name, input logic [4:0] rd, input logic [63:0] addr,
                             input logic [1:0] size, input logic uns, input logic [63:0] pc,
                             input logic [63:0] rdata, input logic [63:0] exp_data, input int gap);
        sb.push_back('{(rd != 5'd0), rd, exp_data, pc});
        set_op(1'b1, 1'b1, rd, addr, size, uns, pc);
        wait_accept(name);
        bus.mem_valid_i = 1'b0;
        for (int i = 0; i < gap; i++) begin
            checks++;
            if (bus.mem_ready_o !== 1'b0 || load_pending_o !== 1'b1 || commit_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait: ready=%b pending=%b commit=%b, want 0/1/0",
                         name, bus.mem_ready_o, load_pending_o, commit_valid_o);
            end
            tick();
        end
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = rdata;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        checks++;
        if (commit_valid_o !== 1'b1 || rf_we_o !== (rd != 5'd0) ||
            (rd != 5'd0 && rf_wdata_o !== exp_data) || bus.mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_result: commit=%b we=%b wdata=%h ready=%b, want 1/%b/%h/1",
                     name, commit_valid_o, rf_we_o, rf_wdata_o, bus.mem_ready_o, (rd != 5'd0), exp_data);
        end
        tick();
    endtask

    task automatic test_loads();
        test_load("ld_b_signed",   5'd10, 64'h8000_0003, 2'd0, 1'b0, 64'h2000,
                  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 2);
        test_load("ld_w_unsigned", 5'd11, 64'h0000_1004, 2'd2, 1'b1, 64'h2004,
                  64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 1);
        test_load("ld_b_unsigned", 5'd12, 64'h0000_0007, 2'd0, 1'b1, 64'h2008,
                  64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 0);
        test_load("ld_h_signed",   5'd13, 64'h0000_0006, 2'd1, 1'b0, 64'h200C,
                  64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 1);
        test_load("ld_h_unsigned", 5'd14, 64'h0000_0002, 2'd1, 1'b1, 64'h2010,
                  64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D, 0);
        test_load("ld_w_signed",   5'd15, 64'h0000_0000, 2'd2, 1'b0, 64'h2014,
                  64'h1111_1111_8000_0000, 64'hFFFF_FFFF_8000_0000, 0);
        test_load("ld_w_misalign", 5'd16, 64'h0000_0005, 2'd2, 1'b0, 64'h2018,
                  64'h7654_3210_89AB_CDEF, 64'h0000_0000_7654_3210, 0);
        test_load("ld_d",          5'd17, 64'h0000_0000, 2'd3, 1'b1, 64'h201C,
                  64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 3);
        test_load("ld_x0",         5'd0,  64'h0000_0000, 2'd3, 1'b0, 64'h2020,
                  64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1);
    endtask

    task automatic test_load_then_op();
        sb.push_back('{1'b1, 5'd20, 64'h0000_0000_0000_0042, 64'h3000});
        sb.push_back('{1'b1, 5'd21, 64'hCAFE, 64'h3004});
        set_op(1'b1, 1'b1, 5'd20, 64'h0000_0001, 2'd0, 1'b1, 64'h3000);
        wait_accept("lto_load");
        set_op(1'b0, 1'b1, 5'd21, 64'hCAFE, 2'd0, 1'b0, 64'h3004);
        tick();
        checks++;
        if (bus.mem_ready_o !== 1'b0 || commit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL lto_held: ready=%b commit=%b, want 0/0", bus.mem_ready_o, commit_valid_o);
        end
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 64'h0000_0000_0000_4200;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd20 || bus.mem_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL lto_load_write: we=%b waddr=%0d ready=%b, want 1/20/1", rf_we_o, rf_waddr_o, bus.mem_ready_o);
        end
        tick();
        bus.mem_valid_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd21 || rf_wdata_o !== 64'hCAFE) begin
            errors++;
            $display("FAIL lto_op_write: we=%b waddr=%0d wdata=%h, want 1/21/cafe", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
    endtask

    task automatic test_x0();
        sb.push_back('{1'b0, 5'd0, 64'h55, 64'h4000});
        set_op(1'b0, 1'b1, 5'd0, 64'h55, 2'd0, 1'b0, 64'h4000);
        wait_accept("x0");
        checks++;
        if (rf_we_o !== 1'b0 || commit_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_write: we=%b commit=%b, want 0/1", rf_we_o, commit_valid_o);
        end
        sb.push_back('{1'b0, 5'd7, 64'h66, 64'h4004});
        set_op(1'b0, 1'b0, 5'd7, 64'h66, 2'd0, 1'b0, 64'h4004);
        wait_accept("nowen");
        bus.mem_valid_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b0 || commit_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL nowen_write: we=%b commit=%b, want 0/1", rf_we_o, commit_valid_o);
        end
        tick();
        checks++;
        if (commit_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_single_pulse: commit=%b, want 0", commit_valid_o);
        end
    endtask

    task automatic test_reset_mid_load();
        set_op(1'b1, 1'b1, 5'd9, 64'h0000_0000, 2'd3, 1'b0, 64'h5000);
        wait_accept("rml");
        bus.mem_valid_i = 1'b0;
        checks++;
        if (load_pending_o !== 1'b1) begin
            errors++;
            $display("FAIL rml_pending: load_pending_o=%b, want 1", load_pending_o);
        end
        rst               = 1'b0;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        tick();
        rst               = 1'b1;
        bus.dmem_rvalid_i = 1'b0;
        checks++;
        if (rf_we_o !== 1'b0 || commit_valid_o !== 1'b0 || bus.mem_ready_o !== 1'b1 || load_pending_o !== 1'b0) begin
            errors++;
            $display("FAIL rml_dropped: we=%b commit=%b ready=%b pending=%b, want 0/0/1/0",
                     rf_we_o, commit_valid_o, bus.mem_ready_o, load_pending_o);
        end
        for (int i = 0; i < 3; i++) begin
            bus.dmem_rvalid_i = 1'b1;
            tick();
            bus.dmem_rvalid_i = 1'b0;
            checks++;
            if (commit_valid_o !== 1'b0 || rf_we_o !== 1'b0 || bus.mem_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rml_stray_rvalid: commit=%b we=%b ready=%b, want 0/0/1",
                         commit_valid_o, rf_we_o, bus.mem_ready_o);
            end
            tick();
        end
        sb.push_back('{1'b1, 5'd3, 64'h77, 64'h5004});
        set_op(1'b0, 1'b1, 5'd3, 64'h77, 2'd0, 1'b0, 64'h5004);
        wait_accept("rml_recover");
        bus.mem_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        bus.mem_valid_i       = 1'b0;
        bus.mem_wen_i         = 1'b0;
        bus.mem_rd_i          = '0;
        bus.mem_result_i      = '0;
        bus.mem_is_load_i     = 1'b0;
        bus.mem_ld_size_i     = '0;
        bus.mem_ld_unsigned_i = 1'b0;
        bus.mem_pc_i          = '0;
        bus.dmem_rvalid_i     = 1'b0;
        bus.dmem_rdata_i      = '0;

        test_reset();
        test_back_to_back();
        test_loads();
        test_load_then_op();
        test_x0();
        test_reset_mid_load();

        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d commits outstanding, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the XPU_v0.1 pipeline, sitting directly upstream of the 31-entry, 64-bit general register file and driving its single write port. It accepts retiring instructions from the MEM stage. Non-load results are written back in one cycle. Loads are held until the data-memory response arrives; the returned doubleword is then lane-selected and sign/zero-extended. Each retired instruction produces one commit pulse for the difftest harness.

## Interface
Parameters:
- XLEN, 64, data width; must match the register file word width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low; sampled at the clk rising edge.
- mem_valid_i  in  1  MEM stage presents a retiring instruction.
- mem_ready_o  out  1  stage can accept; transfer occurs when valid && ready.
- mem_wen_i  in  1  instruction writes rd.
- mem_rd_i  in  RADDR_W  destination register.
- mem_result_i  in  XLEN  ALU result; for loads, the effective address.
- mem_is_load_i  in  1  instruction is a load.
- mem_ld_size_i  in  2  load size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- mem_ld_unsigned_i  in  1  zero-extend instead of sign-extend.
- mem_pc_i  in  XLEN  PC of the instruction.
- dmem_rvalid_i  in  1  load data valid (single-cycle pulse).
- dmem_rdata_i  in  XLEN  aligned doubleword containing the load bytes.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  RADDR_W  register file write address.
- rf_wdata_o  out  XLEN  register file write data.
- commit_valid_o  out  1  one-cycle pulse per retired instruction.
- commit_pc_o  out  XLEN  PC of the retired instruction.
- load_pending_o  out  1  high while in WAIT_LOAD; used by hazard logic.

## Operation
- FSM states: IDLE and WAIT_LOAD.
- mem_ready_o = (state == IDLE).
- IDLE, accepted non-load:
  - next cycle: rf_we_o = mem_wen_i && (mem_rd_i != 0); rf_waddr_o = mem_rd_i; rf_wdata_o = mem_result_i; commit_valid_o = 1; commit_pc_o = mem_pc_i.
  - state stays IDLE.
- IDLE, accepted load:
  - capture rd, wen, offset = mem_result_i[2:0], size, unsigned flag and pc.
  - go to WAIT_LOAD; no write and no commit in this transfer.
- WAIT_LOAD with dmem_rvalid_i:
  - select the lane from dmem_rdata_i. Byte: offset[2:0]. Half: offset[2:1]. Word: offset[2]. Dword: whole word. Lower offset bits below the access size are ignored; misalignment is an upstream responsibility.
  - extend to 64 bits (zero if unsigned; dword is unaffected).
  - next cycle: write and commit pulse, using the same rd == 0 rule as non-loads; state returns to IDLE.
- WAIT_LOAD without rvalid: hold; all pulse outputs stay 0.
- dmem_rvalid_i in IDLE: ignored.
- mem_valid_i while not ready: ignored. Upstream must hold its inputs stable until accepted.
- x0 is never written. rf_we_o = 0 whenever rd == 0, but commit still pulses.

## Timing
- All outputs are registered. On reset (rst = 0 at an edge):
  - state = IDLE.
  - rf_we_o, rf_waddr_o, rf_wdata_o, commit_valid_o, commit_pc_o, load_pending_o = 0.
  - mem_ready_o = 1.
- Non-load latency: accept at edge N → write/commit outputs valid for cycle N+1 only.
- Non-load throughput: one per cycle (back-to-back accepts allowed).
- Load: accept at edge N; rvalid sampled at edge M > N; write/commit valid in cycle M+1.
- mem_ready_o and load_pending_o change at the same edges as the state.
- The earliest next accept after a load is edge M+1, concurrent with the load's write pulse.
- The register file's same-cycle write bypass covers a read of rd during the write cycle.
- Reset while in WAIT_LOAD: the load is dropped; no write and no commit are issued, even if dmem_rvalid_i is high in the same cycle.

## Structure
- Shared package xpu_wb_pkg:
  - load size encodings LD_B, LD_H, LD_W, LD_D.
  - state enum {WB_IDLE, WB_WAIT_LOAD}.
- Sub-module load_extend: purely combinational. Inputs: rdata, offset, size, unsigned. Output: 64-bit extended value. Instantiated once.

## Test plan
- Reset: hold rst = 0 for 3 cycles, then release → all outputs 0, mem_ready_o = 1.
- Back-to-back non-loads:
  - stimulus: rd = 5, result 0x1234, then rd = 6, result 0xFFFF_FFFF_FFFF_FFFF, on consecutive cycles.
  - response: rf_we_o high for 2 consecutive cycles with waddr 5 then 6; two commit pulses with the matching PCs.
- Signed byte load:
  - stimulus: address 0x8000_0003, size 0, signed; after 2 idle cycles, rvalid with rdata 0x0000_0000_8000_0000 (byte 3 = 0x80).
  - response: wdata 0xFFFF_FFFF_FFFF_FF80 one cycle after rvalid; mem_ready_o = 0 throughout the wait.
- Unsigned word load:
  - stimulus: offset 4, size 2, rdata 0xDEAD_BEEF_0000_0000.
  - response: wdata 0x0000_0000_DEAD_BEEF.
- Write to x0:
  - stimulus: rd = 0, wen = 1, result 0x55.
  - response: rf_we_o stays 0; commit_valid_o pulses once.
- Reset mid-load:
  - stimulus: assert rst in WAIT_LOAD in the same cycle as rvalid.
  - response: no write and no commit; state returns to IDLE with mem_ready_o = 1; stray rvalid pulses afterwards are ignored.
